// File: rtl/dram_banked_ctrl.sv
// Multi-bank DRAM model: request/ready access port with 1-cycle registered reads,
// periodic and external refresh serviced round-robin, per-bank retention tracking.
module dram_banked_ctrl #(
  parameter int DATA_W           = 8,
  parameter int ADDR_W           = 6,
  parameter int BANKS            = 4,
  parameter int REFRESH_INTERVAL = 32,
  parameter int REFRESH_CYCLES   = 3,
  parameter int RETENTION        = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     wren,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        d_in,
  input  logic                     refresh,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        d_out,
  output logic                     rd_err,
  output logic                     refreshing,
  output logic [$clog2(BANKS)-1:0] ref_bank
);

  localparam int BANK_W = $clog2(BANKS);
  localparam int TMR_W  = $clog2(REFRESH_INTERVAL);
  localparam int CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int RET_W  = $clog2(RETENTION + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_MAX  = RET_W'(RETENTION);

  typedef enum logic {S_IDLE, S_REFRESH} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cyc_cnt, w_cyc_nxt;
  logic [TMR_W-1:0]   r_ref_timer;
  logic               r_ref_pending;
  logic [BANK_W-1:0]  r_ref_bank;
  logic [RET_W-1:0]   r_ret [BANKS];
  logic [DATA_W-1:0]  r_mem [2**ADDR_W];
  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_d_out;
  logic               r_rd_err;

  logic               w_pend_clr;
  logic               w_ref_done;
  logic               w_tmr_wrap;
  logic               w_req_ready;
  logic               w_fire;
  logic [BANK_W-1:0]  w_bank;
  logic               w_rd_stale;

  assign w_tmr_wrap  = (r_ref_timer == TMR_LAST);
  // A refresh pulse blocks the access arriving in the same cycle so refresh always wins.
  assign w_req_ready = (r_state == S_IDLE) && !r_ref_pending && !refresh && rst;
  assign w_fire      = req_valid && w_req_ready;
  assign w_bank      = addr[ADDR_W-1 -: BANK_W];
  assign w_rd_stale  = (r_ret[w_bank] == RET_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc_cnt;
    w_pend_clr  = 1'b0;
    w_ref_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ref_pending) begin
          w_state_nxt = S_REFRESH;
          w_cyc_nxt   = CYC_LAST;
          w_pend_clr  = 1'b1;
        end
      end
      S_REFRESH: begin
        if (r_cyc_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_ref_done  = 1'b1;
        end else begin
          w_cyc_nxt = r_cyc_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cyc_cnt     <= '0;
      r_ref_timer   <= '0;
      r_ref_pending <= 1'b0;
      r_ref_bank    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc_cnt   <= w_cyc_nxt;
      r_ref_timer <= w_tmr_wrap ? '0 : r_ref_timer + 1'b1;
      // New requests arriving while one is taken are kept, not lost.
      r_ref_pending <= (r_ref_pending && !w_pend_clr) || w_tmr_wrap || refresh;
      if (w_ref_done) r_ref_bank <= r_ref_bank + BANK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BANKS; b++) r_ret[b] <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (w_ref_done && (BANK_W'(b) == r_ref_bank)) r_ret[b] <= '0;
        else if (r_ret[b] != RET_MAX)                 r_ret[b] <= r_ret[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && wren) r_mem[addr] <= d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_d_out    <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_fire && !wren;
      if (w_fire && !wren) begin
        r_d_out  <= w_rd_stale ? '0 : r_mem[addr];
        r_rd_err <= w_rd_stale;
      end
    end
  end

  assign req_ready  = w_req_ready;
  assign rd_valid   = r_rd_valid;
  assign d_out      = r_d_out;
  assign rd_err     = r_rd_err;
  assign refreshing = (r_state == S_REFRESH);
  assign ref_bank   = r_ref_bank;

endmodule

// File: tb/tb_dram_banked_ctrl.sv
// Directed bench for dram_banked_ctrl (RETENTION shortened to 50 so staleness is reachable).
module tb_dram_banked_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       wren;
  logic [5:0] addr;
  logic [7:0] d_in;
  logic       refresh;
  logic       rd_valid;
  logic [7:0] d_out;
  logic       rd_err;
  logic       refreshing;
  logic [1:0] ref_bank;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  dram_banked_ctrl #(
    .DATA_W(8), .ADDR_W(6), .BANKS(4),
    .REFRESH_INTERVAL(32), .REFRESH_CYCLES(3), .RETENTION(50)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .wren(wren), .addr(addr), .d_in(d_in), .refresh(refresh),
    .rd_valid(rd_valid), .d_out(d_out), .rd_err(rd_err),
    .refreshing(refreshing), .ref_bank(ref_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    wren      = 1'b0;
    addr      = '0;
    d_in      = '0;
    refresh   = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic read_at(input int edge_n, input string tag, input logic [7:0] exp_d,
                         input logic exp_e);
    while (cyc < edge_n - 1) tick();
    req_valid = 1'b1;
    wren      = 1'b0;
    addr      = 6'h30;
    #1;
    chk({tag, "_rdy"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk({tag, "_dout"}, d_out, exp_d);
    chk({tag, "_err"}, rd_err, exp_e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_vld", rd_valid, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_refing", refreshing, 0);
    chk("rst_rbank", ref_bank, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    #1;

    // single write then read
    chk("t1_rdy", req_ready, 1);
    req_valid = 1'b1; wren = 1'b1; addr = 6'h05; d_in = 8'hA5;
    tick();
    chk("t1_wr_novld", rd_valid, 0);
    wren = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("t1_vld", rd_valid, 1);
    chk("t1_dout", d_out, 8'hA5);
    chk("t1_err", rd_err, 0);
    tick();
    chk("t1_vld_drop", rd_valid, 0);
    chk("t1_dout_hold", d_out, 8'hA5);

    // back-to-back writes then back-to-back reads
    req_valid = 1'b1; wren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 6'(i); d_in = vals[i];
      tick();
    end
    wren = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 6'(i);
      tick();
      chk("t2_vld", rd_valid, 1);
      chk("t2_dout", d_out, vals[i]);
    end
    req_valid = 1'b0;
    tick();
    chk("t2_vld_drop", rd_valid, 0);

    // free-running periodic refresh
    reset_dut();
    for (int k = 1; k <= 68; k++) begin
      tick();
      if (k == 31) chk("t3_rdy31", req_ready, 1);
      if (k == 32) begin
        chk("t3_refing32", refreshing, 0);
        chk("t3_rdy32", req_ready, 0);
      end
      if (k == 33) chk("t3_refing33", refreshing, 1);
      if (k == 34) chk("t3_rdy34", req_ready, 0);
      if (k == 35) begin
        chk("t3_refing35", refreshing, 1);
        chk("t3_rbank35", ref_bank, 0);
      end
      if (k == 36) begin
        chk("t3_refing36", refreshing, 0);
        chk("t3_rbank36", ref_bank, 1);
        chk("t3_rdy36", req_ready, 1);
      end
      if (k == 64) chk("t3_refing64", refreshing, 0);
      if (k == 65) chk("t3_refing65", refreshing, 1);
      if (k == 68) chk("t3_rbank68", ref_bank, 2);
    end

    // external pulse vs simultaneous request, second pulse during refresh
    reset_dut();
    repeat (5) tick();
    req_valid = 1'b1; wren = 1'b1; addr = 6'h01; d_in = 8'h77; refresh = 1'b1;
    #1;
    chk("t4_rdy_pulse", req_ready, 0);
    tick();
    refresh = 1'b0;
    chk("t4_refing6", refreshing, 0);
    chk("t4_rdy6", req_ready, 0);
    tick();
    chk("t4_refing7", refreshing, 1);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    chk("t4_rdy8", req_ready, 0);
    tick();
    chk("t4_refing9", refreshing, 1);
    tick();
    chk("t4_refing10", refreshing, 0);
    chk("t4_rdy10", req_ready, 0);
    chk("t4_rbank10", ref_bank, 1);
    tick();
    chk("t4_refing11", refreshing, 1);
    repeat (2) tick();
    chk("t4_refing13", refreshing, 1);
    tick();
    chk("t4_refing14", refreshing, 0);
    chk("t4_rbank14", ref_bank, 2);
    chk("t4_rdy14", req_ready, 1);
    tick();
    wren = 1'b0;
    chk("t4_wr_novld", rd_valid, 0);
    tick();
    req_valid = 1'b0;
    chk("t4_vld", rd_valid, 1);
    chk("t4_dout", d_out, 8'h77);
    repeat (4) tick();
    chk("t4_no_third", refreshing, 0);

    // retention: bank3 goes stale at 50 cycles, recovers after its refresh
    reset_dut();
    req_valid = 1'b1; wren = 1'b1; addr = 6'h30; d_in = 8'h5C;
    tick();
    req_valid = 1'b0;
    read_at(50, "t5_fresh", 8'h5C, 1'b0);
    read_at(51, "t5_edge", 8'h00, 1'b1);
    read_at(60, "t5_stale", 8'h00, 1'b1);
    while (cyc < 132) tick();
    chk("t5_rbank_wrap", ref_bank, 0);
    read_at(140, "t5_renew", 8'h5C, 1'b0);

    // reset asserted mid-refresh
    reset_dut();
    req_valid = 1'b1; wren = 1'b0; addr = 6'h05;
    tick();
    req_valid = 1'b0;
    chk("t6_pre_dout", d_out, 8'hA5);
    while (cyc < 34) tick();
    chk("t6_pre_refing", refreshing, 1);
    rst = 1'b0;
    #1;
    chk("t6_refing", refreshing, 0);
    chk("t6_rdy", req_ready, 0);
    chk("t6_vld", rd_valid, 0);
    chk("t6_dout", d_out, 0);
    chk("t6_err", rd_err, 0);
    chk("t6_rbank", ref_bank, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 32) chk("t6_refing32", refreshing, 0);
      if (k == 33) begin
        chk("t6_refing33", refreshing, 1);
        chk("t6_rbank33", ref_bank, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
